// File: rtl/bus_arb_2to1_pkg.sv
// Shared constants for the 2:1 bus arbiter: FSM encoding, mux select values, data width.
package bus_arb_2to1_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/bus_arb_2to1_mux2.sv
// 2:1 datapath mux cell; sel=1 passes in1 (requester A), sel=0 passes in0 (requester B).
module mux2_cell #(
    parameter int W = 16
) (
    input  logic         sel,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in0,
    output logic [W-1:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/bus_arb_2to1_rr_pick.sv
// Two-way round-robin pick: with both requesting, the one that did not win last goes.
module rr_pick (
    input  logic a_valid,
    input  logic b_valid,
    input  logic last_winner,   // 1 = A won the previous grant
    output logic pick_valid,
    output logic pick_is_a
);

    assign pick_valid = a_valid || b_valid;
    assign pick_is_a  = a_valid && (!b_valid || !last_winner);

endmodule

// File: rtl/bus_arb_2to1.sv
// Round-robin burst arbiter for two requesters feeding one registered output stage.
// Optional idle-owner watchdog and arb_err port are enabled with `define ARB_TIMEOUT_EN.
module bus_arb_2to1
    import bus_arb_2to1_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int MAX_BURST   = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    input  logic          a_last,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    input  logic          b_last,
    output logic          b_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          mux_sel,
    output logic          gnt_a,
`ifdef ARB_TIMEOUT_EN
    output logic          gnt_b,
    output logic          arb_err
`else
    output logic          gnt_b
`endif
);

    if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_burst
        $error("bus_arb_2to1: MAX_BURST out of range 2..255");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("bus_arb_2to1: TIMEOUT_CYC out of range 1..255");
    end

    arb_state_t    state, state_nxt;
    logic          last_win_a;
    logic [7:0]    beat_cnt;
    logic          own_a, own_b, slot_free;
    logic [DW-1:0] mux_data;
    logic          own_last, accept, cap_hit, burst_end, timeout;
    logic          pick_valid, pick_is_a;

    assign own_a     = (state == OWN_A);
    assign own_b     = (state == OWN_B);
    assign slot_free = !out_valid || out_ready;
    assign a_ready   = own_a && slot_free;
    assign b_ready   = own_b && slot_free;
    assign gnt_a     = own_a;
    assign gnt_b     = own_b;
    assign mux_sel   = own_b ? SEL_B : SEL_A;

    mux2_cell #(.W(DW)) u_mux (
        .sel (mux_sel),
        .in1 (a_data),
        .in0 (b_data),
        .y   (mux_data)
    );

    assign own_last  = (mux_sel == SEL_A) ? a_last : b_last;
    assign accept    = (a_valid && a_ready) || (b_valid && b_ready);
    assign cap_hit   = (beat_cnt == 8'(MAX_BURST - 1));
    assign burst_end = accept && (own_last || cap_hit);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] idle_cnt;
    logic       own_idle;

    assign own_idle = (own_a && !a_valid) || (own_b && !b_valid);
    assign timeout  = own_idle && (idle_cnt == 8'(TIMEOUT_CYC - 1));
    assign arb_err  = timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    idle_cnt <= '0;
        else if (accept || timeout)    idle_cnt <= '0;
        else if (own_idle)             idle_cnt <= idle_cnt + 8'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    // The owner's own valid is masked: the beat it just handed over says nothing
    // about a further burst, so a lone requester re-enters through IDLE.
    rr_pick u_pick (
        .a_valid     (a_valid && !own_a),
        .b_valid     (b_valid && !own_b),
        .last_winner (last_win_a),
        .pick_valid  (pick_valid),
        .pick_is_a   (pick_is_a)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_valid) state_nxt = pick_is_a ? OWN_A : OWN_B;
            end
            OWN_A, OWN_B: begin
                if (burst_end)    state_nxt = pick_valid ? (pick_is_a ? OWN_A : OWN_B) : IDLE;
                else if (timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            beat_cnt   <= '0;
            last_win_a <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_last  <= own_last || cap_hit;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (burst_end || timeout) beat_cnt <= '0;
            else if (accept)          beat_cnt <= beat_cnt + 8'd1;
            if (burst_end || timeout) last_win_a <= own_a;
        end
    end

endmodule

// File: tb/tb_bus_arb_2to1.sv
// Randomized bench for bus_arb_2to1 against a burst-level round-robin scoreboard.
module tb_bus_arb_2to1;

    localparam int DW = 16;
    localparam int MB = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, a_last, a_ready;
    logic [DW-1:0] a_data;
    logic          b_valid, b_last, b_ready;
    logic [DW-1:0] b_data;
    logic          out_valid, out_last, out_ready;
    logic [DW-1:0] out_data;
    logic          mux_sel, gnt_a, gnt_b;
`ifdef ARB_TIMEOUT_EN
    logic          arb_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    beat_t qa[$];
    beat_t qb[$];

    always #5 clk = ~clk;

    bus_arb_2to1 #(.DW(DW), .MAX_BURST(MB), .TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .mux_sel   (mux_sel),
        .gnt_a     (gnt_a),
`ifdef ARB_TIMEOUT_EN
        .gnt_b     (gnt_b),
        .arb_err   (arb_err)
`else
        .gnt_b     (gnt_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_burst(input bit to_a, input int len, input logic [DW-1:0] base, input bit rnd);
        beat_t bt;
        for (int i = 0; i < len; i++) begin
            bt.d = rnd ? DW'($urandom) : base + DW'(i) * 16'h1111;
            bt.l = (i == len - 1);
            if (to_a) qa.push_back(bt); else qb.push_back(bt);
        end
    endtask

    // Burst-level model: round-robin over non-empty queues, a grant ends on the
    // requester's last flag or after MB beats, starting with A on a tie.
    task automatic build_model(output beat_t eq[$], output bit oq[$]);
        beat_t ma[$], mb[$], bt;
        bit    last_a, pick_a, fl;
        int    n;
        ma = qa; mb = qb; last_a = 1'b0;
        eq.delete(); oq.delete();
        while (ma.size() > 0 || mb.size() > 0) begin
            if (ma.size() > 0 && mb.size() > 0) pick_a = !last_a;
            else                                pick_a = (ma.size() > 0);
            n = 0;
            do begin
                bt = pick_a ? ma.pop_front() : mb.pop_front();
                n++;
                fl = bt.l || (n == MB);
                eq.push_back('{d: bt.d, l: fl});
                oq.push_back(pick_a);
            end while (!fl);
            last_a = pick_a;
        end
    endtask

    task automatic run_stream(input string tag, input int rdy_pct, input bit strict);
        beat_t eq[$];
        bit    oq[$];
        beat_t e;
        bit    af, bf, first_a, own_exp;
        int    k, first_out, last_out, max_gap;
        build_model(eq, oq);
        first_a = oq[0];
        apply_reset();
        k = 0; af = 0; bf = 0; first_out = -1; last_out = -1; max_gap = 0;
        while (eq.size() > 0 && k < 3000) begin
            @(negedge clk);
            if (af) void'(qa.pop_front());
            if (bf) void'(qb.pop_front());
            a_valid = (qa.size() > 0);
            a_data  = a_valid ? qa[0].d : '0;
            a_last  = a_valid ? qa[0].l : 1'b0;
            b_valid = (qb.size() > 0);
            b_data  = b_valid ? qb[0].d : '0;
            b_last  = b_valid ? qb[0].l : 1'b0;
            out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (k == 0) chk({tag, "_idle_gnt"}, {gnt_a, gnt_b}, 2'b00);
            if (k == 1) begin
                chk({tag, "_gnt_lat"}, {gnt_a, gnt_b}, first_a ? 2'b10 : 2'b01);
                chk({tag, "_sel"}, mux_sel, first_a);
            end
            af = a_valid && a_ready;
            bf = b_valid && b_ready;
            if (af || bf) begin
                own_exp = (oq.size() > 0) ? oq.pop_front() : !af;
                chk({tag, "_src"}, af, own_exp);
            end
            if (out_valid && out_ready) begin
                e = eq.pop_front();
                chk({tag, "_data"}, out_data, e.d);
                chk({tag, "_last"}, out_last, e.l);
                if (first_out < 0) first_out = k;
                if (last_out >= 0 && k - last_out > max_gap) max_gap = k - last_out;
                last_out = k;
            end
            k++;
        end
        chk({tag, "_drained"}, eq.size(), 0);
        if (strict) begin
            chk({tag, "_first_out"}, first_out, 2);
            chk({tag, "_gap"}, max_gap, 1);
        end
        @(negedge clk);
        idle_inputs();
        qa.delete(); qb.delete();
        #1 chk({tag, "_end_idle"}, {gnt_a, gnt_b}, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_ready", {a_ready, b_ready}, 2'b00);
        chk("rst_gnt", {gnt_a, gnt_b}, 2'b00);
        chk("rst_mux_sel", mux_sel, 1'b1);

        // single A burst 0x1111/0x2222/0x3333
        add_burst(1'b1, 3, 16'h1111, 1'b0);
        run_stream("t1", 100, 1'b1);

        // tie from reset, two 2-beat bursts, back-to-back switch
        add_burst(1'b1, 2, 16'h1111, 1'b0);
        add_burst(1'b0, 2, 16'h4444, 1'b0);
        run_stream("t2", 100, 1'b1);

        // A 20-beat stream forced to release every MB beats, B interleaves
        add_burst(1'b1, 20, 16'h0000, 1'b1);
        add_burst(1'b0, 3, 16'h0000, 1'b1);
        run_stream("t3", 100, 1'b0);

        // stall with 0xBEEF held in the output register
        apply_reset();
        @(negedge clk); a_valid = 1'b1; a_data = 16'hAAAA; a_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); a_data = 16'hBEEF;
        @(negedge clk); out_ready = 1'b0; a_data = 16'hCCCC; a_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_hold_data", out_data, 16'hBEEF);
            chk("t4_hold_ready", a_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("t4_release", {out_valid, out_data}, {1'b1, 16'hBEEF});
        @(negedge clk); a_valid = 1'b0;
        #1 chk("t4_next", {out_valid, out_last, out_data}, {2'b11, 16'hCCCC});

        // reset mid-burst while B owns
        apply_reset();
        @(negedge clk); b_valid = 1'b1; b_data = 16'h0B01; b_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); b_data = 16'h0B02;
        @(negedge clk);
        #1 chk("t5_pre_gnt", gnt_b, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_gnt", {gnt_a, gnt_b}, 2'b00);
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_mux_sel", mux_sel, 1'b1);
        @(negedge clk); rst_n = 1'b1; a_valid = 1'b1; a_last = 1'b1; b_data = 16'h0B03;
        @(negedge clk);
        #1 chk("t5_tie", {gnt_a, gnt_b}, 2'b10);

`ifdef ARB_TIMEOUT_EN
        // owner goes quiet; watchdog releases and B is granted
        apply_reset();
        @(negedge clk); a_valid = 1'b1; a_data = 16'h0A01; a_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); a_valid = 1'b0; b_valid = 1'b1; b_data = 16'h0B01; b_last = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1 chk("t6_err", arb_err, (i == 4));
            @(negedge clk);
        end
        #1 chk("t6_idle", {gnt_a, gnt_b}, 2'b00);
        @(negedge clk);
        #1 chk("t6_gnt_b", {gnt_a, gnt_b}, 2'b01);
`endif

        // randomized bursts with random downstream backpressure
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < int'($urandom_range(6, 3)); j++) add_burst(1'b1, $urandom_range(12, 1), '0, 1'b1);
            for (int j = 0; j < int'($urandom_range(6, 3)); j++) add_burst(1'b0, $urandom_range(12, 1), '0, 1'b1);
            run_stream($sformatf("rnd%0d", r), 60 + 8 * r, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arb_2to1.md
Name: bus_arb_2to1

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 16-bit datapath.
- Owns the select of the 16-bit 2:1 mux cell; sel=1 routes requester A and sel=0 routes requester B.
- Grants whole bursts with valid/ready handshakes and drives one registered output stage toward the register file/ALU bus.
- Prevents either requester from starving the other by capping burst length.

Parameters:
- DW, 16: data width; must match the mux cell.
- MAX_BURST, 8: maximum beats per grant (2..255). Reaching it forces release.
- TIMEOUT_CYC, 16: idle-owner watchdog limit (1..255). Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a beat.
- a_data  in  DW  requester A beat.
- a_last  in  1  final beat of A's burst.
- a_ready  out  1  A beat accepted when a_valid && a_ready.
- b_valid, b_data, b_last, b_ready: same as the A ports, for requester B.
- out_valid  out  1  registered beat present.
- out_data  out  DW  registered beat.
- out_last  out  1  beat closes a grant (natural or forced).
- out_ready  in  1  downstream accepts.
- mux_sel  out  1  drives the mux cell select; 1=A, 0=B.
- gnt_a, gnt_b  out  1  one-hot ownership flags; both 0 in IDLE.
- arb_err  out  1  watchdog pulse. Present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n=0) values:
  - State=IDLE, out_valid=0, out_data=0, out_last=0.
  - a_ready=b_ready=0, gnt_a=gnt_b=0.
  - mux_sel=1, beat_cnt=0.
  - last_winner=B, so A wins the first tie.
- FSM states are IDLE, OWN_A and OWN_B. The state is registered; ready outputs are combinational from state and the output register.
- IDLE:
  - Neither requester valid: stay in IDLE.
  - Exactly one valid: move to OWN_x.
  - Both valid: move to OWN of the requester that is not last_winner.
  - No beat is accepted in IDLE, so grant latency is 1 cycle.
- OWN_x:
  - mux_sel follows the owner.
  - x_ready = !out_valid || out_ready. The non-owner's ready is 0.
  - Accept when x_valid && x_ready. On accept:
    - out_data <= muxed data, out_valid <= 1, beat_cnt++.
    - out_last <= x_last || (beat_cnt == MAX_BURST-1).
  - out_valid clears when out_ready is high and no new accept occurs that cycle.
- Burst end (the accepted beat has out_last=1):
  - last_winner <= x and beat_cnt <= 0.
  - Next state is re-arbitrated in the same cycle using current valids under the IDLE rule.
  - Switches are back-to-back; there is no bubble beyond the output register.
- Forced release at MAX_BURST:
  - The requester's remaining beats continue in a later grant.
  - The requester sees no error; its x_last is honoured whenever it arrives.
- Stall: out_valid=1 with out_ready=0 holds out_data/out_last stable and deasserts the owner's ready.
- Owner drops valid mid-burst: ownership is kept and the bench waits (see Optional Feature).
- Valid rising while ready is low: no effect on the FSM until the accept occurs.
- rst_n asserted mid-burst: immediate return to reset values. A partially delivered burst is discarded downstream; the arbiter stores nothing.
- beat_cnt is 8 bits and never wraps, because release happens at MAX_BURST.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter runs in OWN_x while x_valid=0 and resets on any accept.
  - When it reaches TIMEOUT_CYC: release to IDLE with last_winner <= x and pulse arb_err for 1 cycle.
  - out_last is not asserted because no beat is produced.
- Undefined: the arb_err port is absent, and the owner holds indefinitely.

Decomposition:
- Shared package/include holds:
  - State encoding localparams: IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10.
  - Mux select constants: SEL_A=1, SEL_B=0.
  - DW default.
- One sub-module, rr_pick (combinational):
  - Inputs: a_valid, b_valid, last_winner.
  - Outputs: pick_valid, pick_is_a.
  - Used from both the IDLE and burst-end paths.
- Data selection instantiates the existing 16-bit 2:1 mux cell with sel=mux_sel.

Test Plan:
1. Reset release, then a_valid=1 with a 3-beat burst 0x1111/0x2222/0x3333 (last on the 3rd), out_ready=1 → gnt_a at cycle 1, out beats in order, out_last on 0x3333, then IDLE.
2. Both valid from reset, 2-beat bursts each → A served first, then B back-to-back with mux_sel 1→0 and no idle cycle; last_winner=B.
3. A streams 20 beats with no last, MAX_BURST=8, B valid → A gets 8 beats with out_last on the 8th, B gets its burst, then A resumes.
4. out_ready held 0 for 5 cycles mid-burst with data 0xBEEF → out_data stays 0xBEEF and a_ready=0; exactly one beat is delivered on release.
5. rst_n pulsed low in OWN_B after 2 beats → same cycle: gnt_b=0, out_valid=0, mux_sel=1; the next tie is won by A.
6. With ARB_TIMEOUT_EN and TIMEOUT_CYC=4: A owns, then drops valid → arb_err pulses on the 4th idle cycle, FSM goes to IDLE, and a pending B is granted next.
